// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART serializer fed by a small word FIFO
// Define UART_TX_PARITY_EN to compile in the parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int DEPTH        = 4,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk_115200hz,
  input  logic                   reset,
  input  logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   out,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW        = $clog2(DEPTH);
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW        = $clog2(STOP_CLKS + 1);
  localparam int BW        = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_CLKS - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      CLKS_PER_BIT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      MSB_FIRST < 0 || MSB_FIRST > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count_q;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Serializer state
  state_t               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 out_q, out_d;
  logic                 start_frame;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [DATA_BITS-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_BITS-1] : v[0];
  endfunction

  function automatic logic [DATA_BITS-1:0] shifted(input logic [DATA_BITS-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != FULL_COUNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;

  always_ff @(posedge clk_115200hz) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    out_d       = out_q;
    pop         = 1'b0;
    done        = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        out_d = 1'b1;
        if (!fifo_empty) begin
          start_frame = 1'b1;
        end
      end

      S_START: begin
        if (clk_cnt_q == BIT_LAST) begin
          out_d     = head_bit(shift_q);
          shift_d   = shifted(shift_q);
          bit_cnt_d = '0;
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            out_d   = parity_q;
            state_d = S_PARITY;
`else
            out_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            out_d     = head_bit(shift_q);
            shift_d   = shifted(shift_q);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          out_d     = 1'b1;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (clk_cnt_q == STOP_LAST) begin
          done = 1'b1;
          // Chain straight into the next start bit when more words wait.
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      shift_d   = mem[rd_ptr];
      out_d     = 1'b0;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      state_d   = S_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      out_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector bench for uart_tx_fifo
// Four instances: defaults, slow/2-stop, MSB-first 7-bit, odd parity.
module tb_uart_tx_fifo;

  logic       clk_115200hz = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  int         sel;

  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] out_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [2:0] count_v [4];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par_even;
  } vec_t;

  vec_t vecs [5];
  logic rec [64];

  always #5 clk_115200hz = ~clk_115200hz;

  assign valid_v = tx_valid ? (4'b0001 << sel) : 4'b0000;

  uart_tx_fifo u_def (
    .clk_115200hz(clk_115200hz), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .fifo_count(count_v[0])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_slow (
    .clk_115200hz(clk_115200hz), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .fifo_count(count_v[1])
  );

  uart_tx_fifo #(.MSB_FIRST(1), .DATA_BITS(7)) u_msb (
    .clk_115200hz(clk_115200hz), .reset(reset), .tx_data(tx_data[6:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .fifo_count(count_v[2])
  );

  uart_tx_fifo #(.PARITY_ODD(1)) u_odd (
    .clk_115200hz(clk_115200hz), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .out(out_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .fifo_count(count_v[3])
  );

  always @(negedge clk_115200hz) begin
    if (done_v[sel] === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_115200hz);
    #1;
  endtask

  function automatic void frame_seq(input vec_t v, input logic odd,
                                    output logic [11:0] seq, output int n);
`ifdef UART_TX_PARITY_EN
    seq = {1'b0, v.frame[9:1], v.par_even ^ odd, v.frame[0]};
    n   = 11;
`else
    seq = {2'b00, v.frame};
    n   = 10;
    if (odd) n = 10;
`endif
  endfunction

  task automatic run_frame(input string name, input logic [7:0] d, input logic [11:0] seq,
                           input int n, input int cpb);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~d;
    check($sformatf("%s count_after_push", name), count_v[sel], 1);
    check($sformatf("%s out_before_pop", name), out_v[sel], 1);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < cpb; c++) begin
        tick();
        check($sformatf("%s out bit%0d cyc%0d", name, i, c), out_v[sel], seq[n-1-i]);
        check($sformatf("%s done bit%0d cyc%0d", name, i, c), done_v[sel],
              (i == n - 1 && c == cpb - 1));
      end
    end
    check($sformatf("%s ready_in_frame", name), ready_v[sel], 1);
    tick();
    check($sformatf("%s out_idle", name), out_v[sel], 1);
    check($sformatf("%s busy_idle", name), busy_v[sel], 0);
    check($sformatf("%s done_idle", name), done_v[sel], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] seq;
    int          n;
    int          k;
    int          acc_n;
    int          base;
    logic        acc;
    logic [11:0] seqs [5];

    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[3] = '{8'h01, 10'b0100000001, 1'b1};
    vecs[4] = '{8'h96, 10'b0011010011, 1'b0};

    sel      = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset out[%0d]", i), out_v[i], 1);
      check($sformatf("reset ready[%0d]", i), ready_v[i], 1);
      check($sformatf("reset busy[%0d]", i), busy_v[i], 0);
      check($sformatf("reset done[%0d]", i), done_v[i], 0);
      check($sformatf("reset count[%0d]", i), count_v[i], 0);
    end
    reset = 1'b0;
    repeat (2) tick();

    // Single frames on the default instance
    for (int v = 0; v < 5; v++) begin
      frame_seq(vecs[v], 1'b0, seq, n);
      run_frame($sformatf("def_%02h", vecs[v].data), vecs[v].data, seq, n, 1);
    end

    sel = 3;
    frame_seq(vecs[0], 1'b1, seq, n);
    run_frame("odd_a5", 8'hA5, seq, n, 1);

    sel = 1;
`ifdef UART_TX_PARITY_EN
    run_frame("slow_01", 8'h01, 12'b010000000111, 12, 3);
`else
    run_frame("slow_01", 8'h01, {1'b0, 11'b01000000011}, 11, 3);
`endif

    sel = 2;
`ifdef UART_TX_PARITY_EN
    run_frame("msb_41", 8'h41, {2'b00, 10'b0100000101}, 10, 1);
`else
    run_frame("msb_41", 8'h41, {3'b000, 9'b010000011}, 9, 1);
`endif

    // Five words back to back: contiguous frames, five done pulses
    sel  = 0;
    base = done_cnt;
    k    = 0;
    for (int v = 0; v < 5; v++) begin
      frame_seq(vecs[v], 1'b0, seq, n);
      seqs[v] = seq;
    end
    for (int t = 0; t <= 5 * n; t++) begin
      tx_valid = (k < 5);
      tx_data  = vecs[(k < 5) ? k : 0].data;
      acc      = tx_valid && ready_v[0];
      tick();
      if (acc) k++;
      if (t >= 1) rec[t-1] = out_v[0];
    end
    tx_valid = 1'b0;
    check("b2b accepted", k, 5);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("b2b frame%0d bit%0d", f, i), rec[f*n+i], seqs[f][n-1-i]);
      end
    end
    tick();
    check("b2b done pulses", done_cnt - base, 5);
    check("b2b busy_after", busy_v[0], 0);
    check("b2b out_after", out_v[0], 1);

    // Overfill: sixth word offered while full is dropped
    base  = done_cnt;
    acc_n = 0;
    for (int t = 0; t < 6; t++) begin
      tx_valid = 1'b1;
      tx_data  = 8'h10 + 8'(t);
      if (ready_v[0]) acc_n++;
      tick();
    end
    check("full accepted", acc_n, 5);
    check("full count", count_v[0], 4);
    check("full ready", ready_v[0], 0);
    tick();
    check("full count_hold", count_v[0], 4);
    tx_valid = 1'b0;
    k = 0;
    while (busy_v[0] && k < 200) begin
      tick();
      k++;
    end
    check("full drained", busy_v[0], 0);
    check("full done pulses", done_cnt - base, 5);

    // Reset during the 4th data bit with two words queued
    for (int t = 0; t < 3; t++) begin
      tx_valid = 1'b1;
      tx_data  = vecs[t].data;
      tick();
    end
    tx_valid = 1'b0;
    repeat (3) tick();
    check("rst queued count", count_v[0], 2);
    check("rst busy_before", busy_v[0], 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst out", out_v[0], 1);
    check("rst count", count_v[0], 0);
    check("rst busy", busy_v[0], 0);
    check("rst ready", ready_v[0], 1);
    check("rst done", done_v[0], 0);
    tick();
    reset = 1'b0;
    base  = done_cnt;
    for (int t = 0; t < 30; t++) begin
      tick();
      check($sformatf("rst quiet out%0d", t), out_v[0], 1);
    end
    check("rst quiet busy", busy_v[0], 0);
    check("rst quiet done", done_cnt - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
